// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path.
//   fsm_state_t : feeder handshake states (F_WAIT / F_ACK / F_LOAD)
//   clogb2      : ceiling log2, also used by the transmitter for counter widths
//   nb_of       : per-channel sample width derived from the transmitter word width
package i2s_pkg;

  typedef enum logic [1:0] {
    F_WAIT = 2'd0,
    F_ACK  = 2'd1,
    F_LOAD = 2'd2
  } fsm_state_t;

  // Ceiling log2 for elaboration-time widths; clogb2(1) = 0, clogb2(4) = 2.
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Each I2S frame carries two channels of equal width.
  function automatic int unsigned nb_of(input int unsigned data_bits);
    return data_bits / 2;
  endfunction

endpackage

// File: rtl/audio_pair_fifo.sv
// Synchronous FIFO holding packed {left,right} audio pairs.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en     : write request, ignored while full
//   wr_data   : pair to store
//   rd_en     : pop request, ignored while empty
//   rd_data   : head-of-queue pair (combinational from the read pointer)
//   full      : level == DEPTH
//   empty     : level == 0
//   level     : entries held, 0..DEPTH inclusive
module audio_pair_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (clogb2(DEPTH) == 0) ? 1 : clogb2(DEPTH),
  localparam int unsigned LW   = clogb2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable after being written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/i2s_xmit_feeder.sv
// Upstream feeder for the I2S transmitter.
// Buffers left/right pairs and hands one {left,right} word per frame to the
// transmitter over the xmit_rdy/xmit_ack handshake.
//   clk, rst       : clock, asynchronous active-high reset
//   in_left/right  : channel samples, in_valid qualifies, in_ready = FIFO not full
//   sample         : word for the transmitter, left in the upper half
//   xmit_rdy       : transmitter latching (re-latches every cycle while high)
//   xmit_ack       : held high from xmit_rdy rise until xmit_rdy falls
//   fifo_level     : entries buffered
//   underrun       : one-cycle pulse when a frame is loaded without data
//   underrun_count : saturating count of underruns, cleared by clear_stats
module i2s_xmit_feeder
  import i2s_pkg::*;
#(
  parameter int unsigned  DATA_BITS     = 32,
  parameter int unsigned  FIFO_DEPTH    = 4,
  parameter bit           UNDERRUN_HOLD = 1'b0,
  parameter int unsigned  CNT_W         = 16,
  localparam int unsigned NB            = nb_of(DATA_BITS),
  localparam int unsigned LW            = clogb2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NB-1:0]        in_left,
  input  logic [NB-1:0]        in_right,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_BITS-1:0] sample,
  input  logic                 xmit_rdy,
  output logic                 xmit_ack,
  output logic [LW-1:0]        fifo_level,
  output logic                 underrun,
  output logic [CNT_W-1:0]     underrun_count,
  input  logic                 clear_stats
);

  fsm_state_t           state;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_wr;
  logic                 fifo_rd;
  logic                 underrun_evt;

  assign in_ready     = (fifo_level != LW'(FIFO_DEPTH));
  assign fifo_wr      = in_valid && in_ready;
  // The FIFO ignores a pop while empty, so the read strobe can cover all of F_LOAD.
  assign fifo_rd      = (state == F_LOAD);
  assign underrun_evt = (state == F_LOAD) && fifo_empty;

  audio_pair_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data ({in_left, in_right}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // sample only moves in F_LOAD, after xmit_rdy has fallen, so it is stable
  // for the whole window in which the transmitter keeps re-latching it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= F_WAIT;
      xmit_ack       <= 1'b0;
      sample         <= '0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      underrun <= 1'b0;
      unique case (state)
        F_WAIT: begin
          if (xmit_rdy) begin
            state    <= F_ACK;
            xmit_ack <= 1'b1;
          end
        end
        F_ACK: begin
          if (!xmit_rdy) begin
            state    <= F_LOAD;
            xmit_ack <= 1'b0;
          end
        end
        F_LOAD: begin
          // xmit_rdy is not examined here; a rise in this cycle is caught in F_WAIT.
          state <= F_WAIT;
          if (!fifo_empty) begin
            sample <= fifo_rd_data;
          end else begin
            underrun <= 1'b1;
            if (!UNDERRUN_HOLD) sample <= '0;
          end
        end
        default: begin
          state    <= F_WAIT;
          xmit_ack <= 1'b0;
        end
      endcase

      if (clear_stats) begin
        underrun_count <= '0;
      end else if (underrun_evt && (underrun_count != '1)) begin
        underrun_count <= underrun_count + CNT_W'(1);
      end
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
